// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard signals between the pipeline (master) and hazard_ctrl (slave)
interface hazard_ctrl_if;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic [4:0] ex_rd_i;
    logic       ex_is_load_i;
    logic       ex_redirect_i;
    logic       imem_ready_i;
    logic       dmem_req_i;
    logic       dmem_ready_i;
    logic       pc_stall_o;
    logic       if2id_stall_o;
    logic       if2id_flush_o;
    logic       id2ex_stall_o;
    logic       id2ex_flush_o;
    logic       ex2mem_stall_o;
    logic       mem2wb_flush_o;
    logic       err_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_is_load_i, ex_redirect_i, imem_ready_i, dmem_req_i, dmem_ready_i,
        input  pc_stall_o, if2id_stall_o, if2id_flush_o, id2ex_stall_o,
               id2ex_flush_o, ex2mem_stall_o, mem2wb_flush_o, err_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_is_load_i, ex_redirect_i, imem_ready_i, dmem_req_i, dmem_ready_i,
        output pc_stall_o, if2id_stall_o, if2id_flush_o, id2ex_stall_o,
               id2ex_flush_o, ex2mem_stall_o, mem2wb_flush_o, err_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I pipeline hazard controller with dmem watchdog
// Optional perf counters enabled by HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt_o,
    output logic [31:0]   perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] L_ONE      = WAIT_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_next_cnt;
    logic              r_err;

    logic w_dwait;
    logic w_lu;
    logic w_pc_stall;
    logic w_if2id_stall;
    logic w_if2id_flush;
    logic w_id2ex_stall;
    logic w_id2ex_flush;
    logic w_ex2mem_stall;
    logic w_mem2wb_flush;

    assign w_dwait = hz.dmem_req_i & ~hz.dmem_ready_i;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_lu = hz.ex_is_load_i & (hz.ex_rd_i != 5'd0) &
                  ((hz.id_rs1_used_i & (hz.id_rs1_i == hz.ex_rd_i)) |
                   (hz.id_rs2_used_i & (hz.id_rs2_i == hz.ex_rd_i)));

    always_comb begin
        w_pc_stall     = 1'b0;
        w_if2id_stall  = 1'b0;
        w_if2id_flush  = 1'b0;
        w_id2ex_stall  = 1'b0;
        w_id2ex_flush  = 1'b0;
        w_ex2mem_stall = 1'b0;
        w_mem2wb_flush = 1'b0;
        if (rst) begin
            w_if2id_flush  = 1'b1;
            w_id2ex_flush  = 1'b1;
            w_mem2wb_flush = 1'b1;
        end else if (r_state == S_ERROR) begin
            w_pc_stall     = 1'b1;
            w_if2id_stall  = 1'b1;
            w_id2ex_stall  = 1'b1;
            w_ex2mem_stall = 1'b1;
        end else if (w_dwait) begin
            w_pc_stall     = 1'b1;
            w_if2id_stall  = 1'b1;
            w_id2ex_stall  = 1'b1;
            w_ex2mem_stall = 1'b1;
            w_mem2wb_flush = 1'b1;
        end else if (hz.ex_redirect_i) begin
            w_if2id_flush  = 1'b1;
            w_id2ex_flush  = 1'b1;
        end else if (w_lu) begin
            w_pc_stall     = 1'b1;
            w_if2id_stall  = 1'b1;
            w_id2ex_flush  = 1'b1;
        end else if (!hz.imem_ready_i) begin
            w_pc_stall     = 1'b1;
            w_if2id_flush  = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (w_dwait) begin
                    w_next_state = S_MEM_WAIT;
                    w_next_cnt   = L_ONE;
                end
            end
            S_MEM_WAIT: begin
                if (!w_dwait) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end else if (r_wait_cnt == L_MAX_WAIT) begin
                    w_next_state = S_ERROR;
                end else if (r_wait_cnt < L_MAX_WAIT) begin
                    w_next_cnt   = r_wait_cnt + L_ONE;
                end
            end
            S_ERROR: begin
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state = S_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            r_err      <= (w_next_state == S_ERROR);
        end
    end

    assign hz.pc_stall_o     = w_pc_stall;
    assign hz.if2id_stall_o  = w_if2id_stall;
    assign hz.if2id_flush_o  = w_if2id_flush;
    assign hz.id2ex_stall_o  = w_id2ex_stall;
    assign hz.id2ex_flush_o  = w_id2ex_flush;
    assign hz.ex2mem_stall_o = w_ex2mem_stall;
    assign hz.mem2wb_flush_o = w_mem2wb_flush;
    assign hz.err_o          = r_err;

`ifdef HAZARD_PERF_EN
    logic        w_perf_stall_inc;
    logic        w_perf_flush_inc;
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    assign w_perf_stall_inc = w_pc_stall & (r_state != S_ERROR);
    assign w_perf_flush_inc = (r_state != S_ERROR) & ~w_dwait & hz.ex_redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_perf_stall_inc) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (w_perf_flush_inc) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf_stall_cnt;
    assign perf_flush_cnt_o = r_perf_flush_cnt;
`endif

endmodule
